// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and width helpers for the SRAM arbiter slice
package mem_pkg;

    localparam logic [0:0] MEM_ARB_IDLE = 1'b0;
    localparam logic [0:0] MEM_ARB_RESP = 1'b1;

    localparam logic [0:0] MEM_PORT_D = 1'b0;
    localparam logic [0:0] MEM_PORT_I = 1'b1;

    function automatic int mem_byte_lanes(input int width);
        return width / 8;
    endfunction

    function automatic int mem_lane_bits(input int width);
        return $clog2(width / 8);
    endfunction

endpackage

// File: rtl/mem_sram_arbiter_if.sv
// rtl/mem_sram_arbiter_if.sv - one requester port: request/grant plus held response channel
interface mem_sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int WIDTH  = 64
);
    logic                 req;
    logic                 gnt;
    logic [ADDR_W-1:0]    addr;
    logic                 wen;
    logic [WIDTH/8-1:0]   strb;
    logic [WIDTH-1:0]     wdata;
    logic                 rvalid;
    logic                 rready;
    logic [WIDTH-1:0]     rdata;
    logic                 err;

    modport master (
        output req, addr, wen, strb, wdata, rready,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, wen, strb, wdata, rready,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - two-way priority pick; ptr names the port that wins a tie
module mem_arb_pick
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (ptr == MEM_PORT_I) begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end else begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_sram_arbiter.sv
// rtl/mem_sram_arbiter.sv - two-port arbiter onto one registered-read SRAM, one access in flight
// MEM_ARB_ROUND_ROBIN_EN selects round robin; otherwise port 0 has fixed priority.
module mem_sram_arbiter
    import mem_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    mem_sram_arbiter_if.slave        r0,
    mem_sram_arbiter_if.slave        r1,
    output logic                     m_cen,
    output logic [WIDTH/8-1:0]       m_wstrb,
    output logic [$clog2(DEPTH)-1:0] m_addr,
    output logic [WIDTH-1:0]         m_wdata,
    input  logic [WIDTH-1:0]         m_rdata,
    input  logic                     m_err
);

    localparam int LB = mem_lane_bits(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int NL = mem_byte_lanes(WIDTH);

    logic [0:0]        state;
    logic              owner_q;
    logic              wen_q;
    logic              oob_q;
    logic [1:0]        req;
    logic [1:0]        pick;
    logic [1:0]        gnt;
    logic              ptr;
    logic              xfer;
    logic              xfer_id;
    logic              slot_free;
    logic              owner_rvalid;
    logic              owner_rready;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wen;
    logic              oob;
    logic              resp_err;
    logic [WIDTH-1:0]  resp_data;

    assign req = {r1.req, r0.req};

    mem_arb_pick u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick)
    );

    assign owner_rvalid = (state == MEM_ARB_RESP);
    assign owner_rready = (owner_q == MEM_PORT_I) ? r1.rready : r0.rready;
    assign slot_free    = (state == MEM_ARB_IDLE) | (owner_rvalid & owner_rready);

    // Reset gates the grant so a requester held high through reset never sees gnt.
    assign gnt     = pick & {2{slot_free & g_resetn}};
    assign r0.gnt  = gnt[0];
    assign r1.gnt  = gnt[1];
    assign xfer    = |(req & gnt);
    assign xfer_id = gnt[1];

    assign sel_addr = xfer_id ? r1.addr : r0.addr;
    assign sel_wen  = xfer_id ? r1.wen  : r0.wen;
    assign oob      = (sel_addr >> (LB + AW)) != '0;

    assign m_cen   = xfer & ~oob;
    assign m_addr  = sel_addr[LB +: AW];
    assign m_wstrb = (xfer_id ? r1.strb : r0.strb) & {NL{sel_wen}};
    assign m_wdata = xfer_id ? r1.wdata : r0.wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr_q;

    always_ff @(posedge g_clk) begin
        if (!g_resetn)  ptr_q <= MEM_PORT_D;
        else if (xfer)  ptr_q <= ~xfer_id;
    end

    assign ptr = ptr_q;
`else
    assign ptr = MEM_PORT_D;
`endif

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state   <= MEM_ARB_IDLE;
            owner_q <= MEM_PORT_D;
            wen_q   <= 1'b0;
            oob_q   <= 1'b0;
        end else if (xfer) begin
            state   <= MEM_ARB_RESP;
            owner_q <= xfer_id;
            wen_q   <= sel_wen;
            oob_q   <= oob;
        end else if (slot_free) begin
            state   <= MEM_ARB_IDLE;
        end
    end

    // The SRAM is not re-enabled while a response is held, so m_rdata/m_err stay valid.
    assign resp_err  = oob_q | m_err;
    assign resp_data = (wen_q | resp_err) ? '0 : m_rdata;

    assign r0.rvalid = owner_rvalid & (owner_q == MEM_PORT_D);
    assign r1.rvalid = owner_rvalid & (owner_q == MEM_PORT_I);
    assign r0.rdata  = r0.rvalid ? resp_data : '0;
    assign r1.rdata  = r1.rvalid ? resp_data : '0;
    assign r0.err    = r0.rvalid & resp_err;
    assign r1.err    = r1.rvalid & resp_err;

endmodule

// File: tb/tb_mem_sram_arbiter.sv
// tb/tb_mem_sram_arbiter.sv - scoreboard bench for mem_sram_arbiter with a behavioural SRAM
module tb_mem_sram_arbiter;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        g_clk;
    logic        g_resetn;
    logic        m_cen;
    logic [7:0]  m_wstrb;
    logic [9:0]  m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic        m_err;
    logic        rom;

    logic [63:0] sram    [0:1023];
    logic [63:0] ref_mem [0:1023];
    exp_t        sb0[$];
    exp_t        sb1[$];
    int          vectors;
    int          misses;

    mem_sram_arbiter_if #(.ADDR_W(32), .WIDTH(64)) r0_if ();
    mem_sram_arbiter_if #(.ADDR_W(32), .WIDTH(64)) r1_if ();

    mem_sram_arbiter #(.WIDTH(64), .DEPTH(1024), .ADDR_W(32)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .r0       (r0_if),
        .r1       (r1_if),
        .m_cen    (m_cen),
        .m_wstrb  (m_wstrb),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_err    (m_err)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // SRAM macro: registered read, byte strobes, err on write when configured as ROM.
    always @(posedge g_clk) begin
        if (m_cen) begin
            if (m_wstrb != 8'h00) begin
                m_err <= rom;
                if (!rom)
                    for (int b = 0; b < 8; b++)
                        if (m_wstrb[b]) sram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            end else begin
                m_rdata <= sram[m_addr];
                m_err   <= 1'b0;
            end
        end
    end

    task automatic drive(input int p, input logic rq, input logic [31:0] a, input logic w,
                         input logic [7:0] s, input logic [63:0] d);
        if (p == 0) begin
            r0_if.req = rq; r0_if.addr = a; r0_if.wen = w; r0_if.strb = s; r0_if.wdata = d;
        end else begin
            r1_if.req = rq; r1_if.addr = a; r1_if.wen = w; r1_if.strb = s; r1_if.wdata = d;
        end
    endtask

    task automatic sb_push(input int p, input logic [31:0] a, input logic w,
                           input logic [7:0] s, input logic [63:0] d);
        exp_t       e;
        logic [9:0] wi;
        wi = a[12:3];
        e  = '{rdata: 64'h0, err: 1'b0};
        if (a[31:13] != 19'h0) e.err = 1'b1;
        else if (w) begin
            if (rom && s != 8'h00) e.err = 1'b1;
            else
                for (int b = 0; b < 8; b++)
                    if (s[b]) ref_mem[wi][8*b +: 8] = d[8*b +: 8];
        end else e.rdata = ref_mem[wi];
        if (p == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic tick;
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_reset;
        g_resetn = 1'b0;
        drive(0, 1'b1, 32'h10, 1'b0, 8'h00, 64'h0);
        drive(1, 1'b1, 32'h18, 1'b0, 8'h00, 64'h0);
        repeat (4) begin
            @(negedge g_clk);
            vectors++;
            if ({r0_if.gnt, r1_if.gnt, m_cen, r0_if.rvalid, r1_if.rvalid, r0_if.err, r1_if.err} !== 7'b0
                || r0_if.rdata !== 64'h0) begin
                misses++;
                $display("FAIL reset_outputs: gnt0/gnt1/cen/rv0/rv1/err0/err1=%b rdata0=%h required all 0",
                         {r0_if.gnt, r1_if.gnt, m_cen, r0_if.rvalid, r1_if.rvalid, r0_if.err, r1_if.err},
                         r0_if.rdata);
            end
        end
        tick();
        drive(0, 1'b0, 32'h0, 1'b0, 8'h00, 64'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 8'h00, 64'h0);
        g_resetn = 1'b1;
    endtask

    task automatic test_single;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive(0, 1'b1, 32'h10, 1'b1, 8'h0F, 64'h1122334455667788);
            else        drive(0, 1'b1, 32'h10, 1'b0, 8'h00, 64'h0);
            @(negedge g_clk);
            vectors++;
            if ({r0_if.gnt, r0_if.rvalid, m_cen} !== 3'b101) begin
                misses++;
                $display("FAIL single_gnt%0d: gnt/rvalid/cen=%b required 101", k,
                         {r0_if.gnt, r0_if.rvalid, m_cen});
            end
            sb_push(0, r0_if.addr, r0_if.wen, r0_if.strb, r0_if.wdata);
            tick();
            drive(0, 1'b0, 32'h0, 1'b0, 8'h00, 64'h0);
            @(negedge g_clk);
            e = sb0.pop_front();
            vectors++;
            if ({r0_if.rvalid, r0_if.rdata, r0_if.err} !== {1'b1, e.rdata, e.err}) begin
                misses++;
                $display("FAIL single_resp%0d: rvalid=%b rdata=%h err=%b required 1 %h %b", k,
                         r0_if.rvalid, r0_if.rdata, r0_if.err, e.rdata, e.err);
            end
            tick();
        end
        vectors++;
        if (ref_mem[2] !== 64'h0000000055667788) begin
            misses++;
            $display("FAIL single_strobe_merge: model word=%h required 0000000055667788", ref_mem[2]);
        end
    endtask

    task automatic test_contention;
        exp_t e;
        int   g0, g1, resp, last, cur;
        bit   alt_ok;
        g0 = 0; g1 = 0; resp = 0; last = -1; alt_ok = 1'b1;
        r0_if.rready = 1'b1;
        r1_if.rready = 1'b1;
        drive(0, 1'b1, 32'h10, 1'b0, 8'h00, 64'h0);
        drive(1, 1'b1, 32'h18, 1'b0, 8'h00, 64'h0);
        for (int c = 0; c <= 8; c++) begin
            @(negedge g_clk);
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? r0_if.rvalid : r1_if.rvalid) begin
                    resp++;
                    vectors++;
                    if (((p == 0) ? sb0.size() : sb1.size()) == 0) begin
                        misses++;
                        $display("FAIL contention_unexpected_resp: port %0d has no outstanding request", p);
                    end else begin
                        e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
                        if (((p == 0) ? {r0_if.rdata, r0_if.err} : {r1_if.rdata, r1_if.err})
                            !== {e.rdata, e.err}) begin
                            misses++;
                            $display("FAIL contention_resp: port %0d rdata/err=%h required %h", p,
                                     (p == 0) ? {r0_if.rdata, r0_if.err} : {r1_if.rdata, r1_if.err},
                                     {e.rdata, e.err});
                        end
                    end
                end
            end
            if (c < 8) begin
                vectors++;
                if ((r0_if.gnt + r1_if.gnt) != 1) begin
                    misses++;
                    $display("FAIL contention_one_gnt: cycle %0d gnt0=%b gnt1=%b required exactly one",
                             c, r0_if.gnt, r1_if.gnt);
                end
                cur = r1_if.gnt ? 1 : 0;
                if (cur == 0) g0++; else g1++;
                if (cur == last) alt_ok = 1'b0;
                last = cur;
                sb_push(cur, (cur == 0) ? 32'h10 : 32'h18, 1'b0, 8'h00, 64'h0);
                tick();
                if (c == 7) begin
                    drive(0, 1'b0, 32'h0, 1'b0, 8'h00, 64'h0);
                    drive(1, 1'b0, 32'h0, 1'b0, 8'h00, 64'h0);
                end
            end
        end
        tick();
        vectors++;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (g0 != 4 || g1 != 4 || !alt_ok || resp != 8) begin
            misses++;
            $display("FAIL contention_rr: g0=%0d g1=%0d alternating=%0d responses=%0d required 4 4 1 8",
                     g0, g1, alt_ok, resp);
        end
`else
        if (g0 != 8 || g1 != 0 || resp != 8) begin
            misses++;
            $display("FAIL contention_fixed: g0=%0d g1=%0d responses=%0d required 8 0 8", g0, g1, resp);
        end
`endif
    endtask

    task automatic test_backpressure;
        exp_t e;
        r0_if.rready = 1'b1;
        r1_if.rready = 1'b0;
        drive(1, 1'b1, 32'h10, 1'b0, 8'h00, 64'h0);
        @(negedge g_clk);
        vectors++;
        if (r1_if.gnt !== 1'b1) begin
            misses++;
            $display("FAIL bp_gnt1: gnt1=%b required 1", r1_if.gnt);
        end
        sb_push(1, 32'h10, 1'b0, 8'h00, 64'h0);
        tick();
        drive(1, 1'b0, 32'h0, 1'b0, 8'h00, 64'h0);
        drive(0, 1'b1, 32'h18, 1'b0, 8'h00, 64'h0);
        repeat (5) begin
            @(negedge g_clk);
            vectors++;
            if ({r1_if.rvalid, r1_if.rdata, r0_if.gnt, r1_if.gnt, m_cen} !== {1'b1, sb1[0].rdata, 3'b000}) begin
                misses++;
                $display("FAIL bp_hold: rvalid1=%b rdata1=%h gnt0/gnt1/cen=%b required 1 %h 000",
                         r1_if.rvalid, r1_if.rdata, {r0_if.gnt, r1_if.gnt, m_cen}, sb1[0].rdata);
            end
            tick();
        end
        r1_if.rready = 1'b1;
        @(negedge g_clk);
        e = sb1.pop_front();
        vectors++;
        if ({r0_if.gnt, r1_if.rvalid, r1_if.rdata, r1_if.err} !== {2'b11, e.rdata, e.err}) begin
            misses++;
            $display("FAIL bp_release: gnt0=%b rvalid1=%b rdata1=%h err1=%b required 1 1 %h %b",
                     r0_if.gnt, r1_if.rvalid, r1_if.rdata, r1_if.err, e.rdata, e.err);
        end
        sb_push(0, 32'h18, 1'b0, 8'h00, 64'h0);
        tick();
        drive(0, 1'b0, 32'h0, 1'b0, 8'h00, 64'h0);
        @(negedge g_clk);
        e = sb0.pop_front();
        vectors++;
        if ({r0_if.rvalid, r0_if.rdata, r0_if.err} !== {1'b1, e.rdata, e.err}) begin
            misses++;
            $display("FAIL bp_next_resp: rvalid0=%b rdata0=%h err0=%b required 1 %h %b",
                     r0_if.rvalid, r0_if.rdata, r0_if.err, e.rdata, e.err);
        end
        tick();
    endtask

    task automatic test_out_of_range;
        exp_t e;
        drive(0, 1'b1, 32'h0000_2000, 1'b0, 8'h00, 64'h0);
        @(negedge g_clk);
        vectors++;
        if ({r0_if.gnt, m_cen} !== 2'b10) begin
            misses++;
            $display("FAIL oob_issue: gnt0/cen=%b required 10", {r0_if.gnt, m_cen});
        end
        sb_push(0, 32'h0000_2000, 1'b0, 8'h00, 64'h0);
        tick();
        drive(0, 1'b0, 32'h0, 1'b0, 8'h00, 64'h0);
        @(negedge g_clk);
        e = sb0.pop_front();
        vectors++;
        if ({r0_if.rvalid, r0_if.rdata, r0_if.err} !== {1'b1, e.rdata, e.err}) begin
            misses++;
            $display("FAIL oob_resp: rvalid0=%b rdata0=%h err0=%b required 1 %h %b",
                     r0_if.rvalid, r0_if.rdata, r0_if.err, e.rdata, e.err);
        end
        tick();
    endtask

    task automatic test_rom_reset;
        exp_t e;
        rom = 1'b1;
        r1_if.rready = 1'b0;
        drive(1, 1'b1, 32'h18, 1'b1, 8'h3C, 64'hDEADBEEFCAFEF00D);
        @(negedge g_clk);
        vectors++;
        if ({r1_if.gnt, m_cen} !== 2'b11) begin
            misses++;
            $display("FAIL rom_issue: gnt1/cen=%b required 11", {r1_if.gnt, m_cen});
        end
        sb_push(1, 32'h18, 1'b1, 8'h3C, 64'hDEADBEEFCAFEF00D);
        tick();
        drive(1, 1'b0, 32'h0, 1'b0, 8'h00, 64'h0);
        @(negedge g_clk);
        e = sb1.pop_front();
        vectors++;
        if ({r1_if.rvalid, r1_if.rdata, r1_if.err} !== {1'b1, e.rdata, e.err}) begin
            misses++;
            $display("FAIL rom_resp: rvalid1=%b rdata1=%h err1=%b required 1 %h %b",
                     r1_if.rvalid, r1_if.rdata, r1_if.err, e.rdata, e.err);
        end
        tick();
        g_resetn = 1'b0;
        tick();
        g_resetn = 1'b1;
        r1_if.rready = 1'b1;
        repeat (3) begin
            @(negedge g_clk);
            vectors++;
            if ({r0_if.rvalid, r1_if.rvalid, r1_if.err} !== 3'b000) begin
                misses++;
                $display("FAIL rom_reset_drop: rvalid0/rvalid1/err1=%b required 000",
                         {r0_if.rvalid, r1_if.rvalid, r1_if.err});
            end
            tick();
        end
        vectors++;
        if (sb0.size() + sb1.size() != 0) begin
            misses++;
            $display("FAIL scoreboard_drain: %0d outstanding required 0", sb0.size() + sb1.size());
        end
        rom = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors = 0;
        misses  = 0;
        rom     = 1'b0;
        m_rdata = 64'h0;
        m_err   = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            sram[i]    = 64'h0;
            ref_mem[i] = 64'h0;
        end
        g_resetn = 1'b0;
        r0_if.rready = 1'b1;
        r1_if.rready = 1'b1;
        drive(0, 1'b0, 32'h0, 1'b0, 8'h00, 64'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 8'h00, 64'h0);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_out_of_range();
        test_rom_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
